uart_echo_engine: RTL and testbench

- Parametrised message-transform and buffering stage between the UART receiver wrapper and the transmitter wrapper.
- Each received message is NUM_CHARS ASCII characters. Each character is case-transformed according to a mode input, then buffered in a DEPTH-entry FIFO.
- Messages are handed to the transmitter one at a time, using its ready/isNew handshake.
- Full-FIFO drops are counted, never silently lost.

---
 rtl/uart_echo_pkg.sv | 44 ++++
 rtl/uart_msg_fifo.sv | 59 +++++
 rtl/uart_echo_engine.sv | 131 +++++++++++++
 tb/tb_uart_echo_engine.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared constants, state/mode types and the per-character ASCII case transform
// used by the UART echo engine.
package uart_echo_pkg;

   localparam int CHAR_W = 8;

   localparam logic [CHAR_W-1:0] UPPER_A  = 8'h41;
   localparam logic [CHAR_W-1:0] UPPER_Z  = 8'h5A;
   localparam logic [CHAR_W-1:0] LOWER_A  = 8'h61;
   localparam logic [CHAR_W-1:0] LOWER_Z  = 8'h7A;
   localparam logic [CHAR_W-1:0] CASE_BIT = 8'h20;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_TOGGLE = 2'd1,
      MODE_UPPER  = 2'd2,
      MODE_LOWER  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BUSY  = 2'd1,
      WAIT_READY = 2'd2
   } tx_state_e;

   // Only letters are touched; bytes just outside the letter ranges pass unchanged.
   function automatic logic [CHAR_W-1:0] xform_char(input logic [CHAR_W-1:0] c,
                                                    input mode_e m);
      logic is_upper;
      logic is_lower;
      logic [CHAR_W-1:0] r;
      is_upper = (c >= UPPER_A) && (c <= UPPER_Z);
      is_lower = (c >= LOWER_A) && (c <= LOWER_Z);
      r = c;
      case (m)
         MODE_TOGGLE: if (is_upper || is_lower) r = c ^ CASE_BIT;
         MODE_UPPER:  if (is_lower) r = c & ~CASE_BIT;
         MODE_LOWER:  if (is_upper) r = c | CASE_BIT;
         default:     r = c;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_msg_fifo.sv
// Synchronous message FIFO with occupancy count; the caller only pushes when
// not full (or popping in the same cycle) and only pops when not empty.
module uart_msg_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/uart_echo_engine.sv
// Case-transforms received messages, queues them and hands them one at a time to
// the transmitter. Define UART_NULL_FILTER_EN to discard all-zero messages.
module uart_echo_engine
   import uart_echo_pkg::*;
#(
   parameter int NUM_CHARS   = 4,
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 16,
   parameter int DROP_CNT_W  = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        rx_valid,
   input  logic [8*NUM_CHARS-1:0]      rx_message,
   input  logic [1:0]                  mode,
   input  logic                        tx_ready,
   output logic                        tx_valid,
   output logic [8*NUM_CHARS-1:0]      tx_message,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic                        overflow,
   output logic [DROP_CNT_W-1:0]       drop_count
);

   localparam int MSG_W = CHAR_W * NUM_CHARS;
   localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   tx_state_e             state_q, state_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [MSG_W-1:0]      tx_message_q, tx_message_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

   logic [MSG_W-1:0] xform_msg;
   logic [MSG_W-1:0] fifo_head;
   logic             fifo_full, fifo_empty;
   logic             rx_take, push, pop, drop;

   always_comb begin
      xform_msg = '0;
      for (int i = 0; i < NUM_CHARS; i++) begin
         xform_msg[CHAR_W*i +: CHAR_W] = xform_char(rx_message[CHAR_W*i +: CHAR_W], mode_e'(mode));
      end
   end

`ifdef UART_NULL_FILTER_EN
   assign rx_take = rx_valid && (rx_message != '0);
`else
   assign rx_take = rx_valid;
`endif

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push = rx_take && (!fifo_full || pop);
   assign drop = rx_take && fifo_full && !pop;

   uart_msg_fifo #(
      .WIDTH (MSG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (xform_msg),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      tx_valid_d   = 1'b0;
      tx_message_d = tx_message_q;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && tx_ready) begin
               pop          = 1'b1;
               tx_valid_d   = 1'b1;
               tx_message_d = fifo_head;
               timer_d      = '0;
               state_d      = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // No busy indication within the window means the send was taken.
            if (!tx_ready)                 state_d = WAIT_READY;
            else if (timer_q == TMR_LAST)  state_d = IDLE;
            else                           timer_d = timer_q + 1'b1;
         end
         WAIT_READY: begin
            if (tx_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign overflow_d   = overflow_q | drop;
   assign drop_count_d = drop ? sat_inc(drop_count_q) : drop_count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         tx_valid_q   <= 1'b0;
         tx_message_q <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         tx_valid_q   <= tx_valid_d;
         tx_message_q <= tx_message_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_valid   = tx_valid_q;
   assign tx_message = tx_message_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Self-checking bench for uart_echo_engine: directed handshake/FIFO cases plus a
// randomized run scored against a queue-based reference model.
module tb_uart_echo_engine;

   localparam int NUM_CHARS   = 4;
   localparam int DEPTH       = 4;
   localparam int ACK_TIMEOUT = 16;
   localparam int DROP_CNT_W  = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [31:0] rx_message;
   logic [1:0]  mode;
   logic        tx_ready;
   logic        tx_valid;
   logic [31:0] tx_message;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic [7:0]  drop_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   uart_echo_engine #(
      .NUM_CHARS   (NUM_CHARS),
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .DROP_CNT_W  (DROP_CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_message (rx_message),
      .mode       (mode),
      .tx_ready   (tx_ready),
      .tx_valid   (tx_valid),
      .tx_message (tx_message),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference transform: shift letters between cases by +/-32.
   function automatic logic [31:0] ref_xform(input logic [31:0] msg, input int m);
      logic [31:0] r;
      int c;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         c = int'(msg[8*i +: 8]);
         if (c >= 65 && c <= 90) begin
            if (m == 1 || m == 3) c = c + 32;
         end else if (c >= 97 && c <= 122) begin
            if (m == 1 || m == 2) c = c - 32;
         end
         r[8*i +: 8] = 8'(c);
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_msg();
      logic [31:0] r;
      logic [7:0]  b;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(0, 9))
            0: b = 8'h40;
            1: b = 8'h41;
            2: b = 8'h5A;
            3: b = 8'h5B;
            4: b = 8'h60;
            5: b = 8'h61;
            6: b = 8'h7A;
            7: b = 8'h7B;
            8: b = 8'h00;
            default: b = 8'($urandom_range(0, 255));
         endcase
         r[8*i +: 8] = b;
      end
      if (r == 32'h0) r = 32'h0000_0041;
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] msg, input int m);
      rx_valid   = 1'b1;
      rx_message = msg;
      mode       = 2'(m);
      step();
      rx_valid   = 1'b0;
   endtask

   task automatic wait_tx(input int max, input string tag);
      int cyc;
      cyc = 0;
      while (tx_valid !== 1'b1 && cyc < max) begin
         step();
         cyc++;
      end
      check({tag, "_seen"}, tx_valid, 1);
   endtask

   // Transmitter goes busy then idle again, releasing the FSM back to IDLE.
   task automatic ack();
      tx_ready = 1'b0;
      step();
      check("ack_pulse_end", tx_valid, 0);
      tx_ready = 1'b1;
      step();
   endtask

   task automatic watch_no_tx(input int n, input string tag);
      int p;
      p = 0;
      repeat (n) begin
         step();
         if (tx_valid === 1'b1) p++;
      end
      check(tag, p, 0);
   endtask

   task automatic send_check(input logic [31:0] msg, input int m, input logic [31:0] exp,
                             input string tag);
      tx_ready = 1'b1;
      push_one(msg, m);
      check({tag, "_lat1"}, tx_valid, 0);
      step();
      check({tag, "_lat2"}, tx_valid, 1);
      check({tag, "_msg"}, tx_message, exp);
      ack();
   endtask

   logic [31:0] msgs [6];
   int          mds  [6];
   logic [31:0] exp_q [$];
   int          gap;
   int          outstanding;
   logic        prev_v;
   logic [31:0] m_r;
   int          md_r;

   initial begin
      rx_message = '0;
      mode       = '0;
      do_reset();

      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_message", tx_message, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);

      send_check(32'h6142337A, 1, 32'h4162335A, "toggle");
      send_check(32'h6142337A, 2, 32'h4142335A, "upper");
      send_check(32'h6142337A, 3, 32'h6162337A, "lower");
      send_check(32'h6142337A, 0, 32'h6142337A, "pass");
      send_check(32'h405B607B, 1, 32'h405B607B, "bounds");

      // Six pushes into a stalled transmitter: two are dropped.
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         msgs[i]    = rand_msg();
         mds[i]     = $urandom_range(0, 3);
         rx_valid   = 1'b1;
         rx_message = msgs[i];
         mode       = 2'(mds[i]);
         step();
      end
      rx_valid = 1'b0;
      check("ovf_count", fifo_count, 4);
      check("ovf_flag", overflow, 1);
      check("ovf_drops", drop_count, 2);
      for (int i = 0; i < 4; i++) begin
         tx_ready = 1'b1;
         wait_tx(40, "ovf_drain");
         check("ovf_drain_msg", tx_message, ref_xform(msgs[i], mds[i]));
         watch_no_tx(3, "ovf_no_dup");
         tx_ready = 1'b0;
         step();
         tx_ready = 1'b1;
         step();
      end
      step();
      check("ovf_empty", fifo_count, 0);
      check("ovf_sticky", overflow, 1);

      // Full FIFO with a pop in the same cycle as the push.
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         msgs[i]    = rand_msg();
         mds[i]     = $urandom_range(0, 3);
         rx_valid   = 1'b1;
         rx_message = msgs[i];
         mode       = 2'(mds[i]);
         step();
      end
      check("full_count", fifo_count, 4);
      msgs[4]    = rand_msg();
      mds[4]     = $urandom_range(0, 3);
      rx_message = msgs[4];
      mode       = 2'(mds[4]);
      tx_ready   = 1'b1;
      step();
      rx_valid = 1'b0;
      check("pushpop_count", fifo_count, 4);
      check("pushpop_drops", drop_count, 2);
      check("pushpop_tx", tx_valid, 1);
      check("pushpop_msg0", tx_message, ref_xform(msgs[0], mds[0]));
      for (int i = 1; i < 5; i++) begin
         ack();
         wait_tx(40, "pushpop_drain");
         check("pushpop_msg", tx_message, ref_xform(msgs[i], mds[i]));
      end
      ack();
      check("pushpop_empty", fifo_count, 0);

      // Ack timeout: transmitter never signals busy.
      tx_ready = 1'b0;
      msgs[0] = rand_msg();
      msgs[1] = rand_msg();
      push_one(msgs[0], 0);
      push_one(msgs[1], 2);
      tx_ready = 1'b1;
      wait_tx(10, "tmo_first");
      check("tmo_msg0", tx_message, msgs[0]);
      gap = 0;
      do begin
         step();
         gap++;
      end while (tx_valid !== 1'b1 && gap < 40);
      check("tmo_gap", gap, ACK_TIMEOUT + 1);
      check("tmo_msg1", tx_message, ref_xform(msgs[1], 2));
      ack();

      // Reset during WAIT_BUSY with three messages still queued.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_one(rand_msg(), 1);
      check("rstb_drops", drop_count, 3);
      tx_ready = 1'b1;
      wait_tx(10, "rstb_send");
      check("rstb_queued", fifo_count, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstb_count", fifo_count, 0);
      check("rstb_tx_valid", tx_valid, 0);
      check("rstb_overflow", overflow, 0);
      check("rstb_drop_count", drop_count, 0);
      watch_no_tx(20, "rstb_quiet");
      send_check(32'h7A7A4141, 2, 32'h5A5A4141, "rstb_after");

`ifdef UART_NULL_FILTER_EN
      push_one(32'h0, 1);
      check("null_count", fifo_count, 0);
      watch_no_tx(5, "null_no_tx");
      check("null_overflow", overflow, 0);
`else
      send_check(32'h0, 1, 32'h0, "null_pass");
`endif

      // Randomized run against the queue model; pushes are throttled so no drop occurs.
      do_reset();
      exp_q.delete();
      outstanding = 0;
      prev_v      = 1'b0;
      tx_ready    = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
         step();
         if (tx_valid === 1'b1) begin
            check("rnd_no_back2back", prev_v, 0);
            if (exp_q.size() == 0) begin
               check("rnd_unexpected_tx", tx_valid, 0);
            end else begin
               check("rnd_msg", tx_message, exp_q.pop_front());
               outstanding--;
            end
         end
         prev_v   = tx_valid;
         tx_ready = ($urandom_range(0, 3) != 0);
         rx_valid = 1'b0;
         if (cyc < 500 && outstanding <= DEPTH - 2 && $urandom_range(0, 1) == 1) begin
            m_r        = rand_msg();
            md_r       = $urandom_range(0, 3);
            rx_valid   = 1'b1;
            rx_message = m_r;
            mode       = 2'(md_r);
            exp_q.push_back(ref_xform(m_r, md_r));
            outstanding++;
         end
      end
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_count", fifo_count, 0);
      check("rnd_overflow", overflow, 0);
      check("rnd_drops", drop_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
